hcsr04_scan: RTL and testbench
==============================

Name: hcsr04_scan

Overview:
- Round-robin scheduler that shares one hcsr04 ranging engine between up to N_CH ultrasonic sensors.
- Drives the engine's enable and the channel select for the external trig/echo mux.
- Enforces an inter-measurement guard gap and a watchdog timeout.
- Stores one result per channel in a register bank, read back through a registered port.

Parameters:
N_CH, 4, number of sensor channels (2..16)
CH_W, 2, width of channel index (clog2 N_CH)
CAP_LEN, 16, result width; matches engine len
GAP_CYC, 3000000, clk50M cycles of guard between measurements (60 ms)
GAP_W, 22, width of gap counter
TMO_CYC, 2500000, clk50M cycles before a measurement is declared timed out (50 ms)
TMO_W, 22, width of watchdog counter

Ports:
clk50M  in  1  50 MHz clock; sole clock
rst  in  1  reset, synchronous, active-low
run  in  1  level; 1 = keep scanning
ch_mask  in  N_CH  channel enable mask; bit i = scan channel i
rng_en  out  1  enable to ranging engine
rng_done  in  1  engine done (high when idle/result valid, low while measuring)
rng_len  in  CAP_LEN  engine result
sel  out  CH_W  active channel, drives trig/echo mux
rd_ch  in  CH_W  readback channel
rd_len  out  CAP_LEN  stored result of rd_ch, 1-cycle latency
rd_vld  out  N_CH  bit i = channel i holds at least one result since reset
err  out  N_CH  bit i = last measurement of channel i timed out
busy  out  1  high in any state other than IDLE
sweep_done  out  1  one-cycle pulse when scan wraps past the last enabled channel

Behaviour:
- Reset (rst==0 at posedge clk50M):
  - state=IDLE; sel=0; rng_en=0; busy=0; sweep_done=0; rd_len=0; rd_vld=0; err=0; all stored lengths 0; counters 0.
  - Reset mid-measurement aborts immediately; the engine is not reset by this block.
- States and transitions:
  - IDLE: leave when run==1, ch_mask!=0 and rng_done==1. Choose the first enabled channel at or after the current sel (round-robin, wrap at N_CH-1→0), load sel, go to ARM.
  - ARM: rng_en=1. When rng_done==0, drop rng_en, clear the watchdog, go to MEAS.
  - MEAS: rng_en=0. Watchdog increments each cycle.
    - rng_done==1 → STORE.
    - Watchdog reaches TMO_CYC-1 → TOUT.
  - The watchdog also runs in ARM; expiry in ARM → TOUT.
  - STORE (1 cycle): len[sel]<=rng_len; err[sel]<=0; rd_vld[sel]<=1 → GAP.
  - TOUT (1 cycle): len[sel]<={CAP_LEN{1'b1}}; err[sel]<=1; rd_vld[sel]<=1 → GAP.
  - GAP: count GAP_CYC cycles, then:
    - If run==0 or ch_mask==0 → IDLE.
    - Otherwise pick the next enabled channel strictly after sel (wrap) and go to ARM with the new sel. ARM additionally waits for rng_done==1 before asserting rng_en.
- sweep_done: pulses in the cycle GAP exits, when the next selected index is <= current sel (wrap). With a single enabled channel it pulses every measurement.
- ch_mask is sampled only at channel selection. A channel disabled mid-measurement still completes.
- run deasserted mid-measurement: the measurement and its GAP complete, then IDLE. The gap is never shortened.
- Readback: rd_len <= len[rd_ch] every cycle. A write and a read of the same channel in the same cycle return the old value; the new value appears on the next cycle.
- sel changes only on the ARM entry cycle, never while rng_en or measurement is active.
- Counter widths must hold TMO_CYC and GAP_CYC. A parameter mismatch is an elaboration error (assertion in sim).

Optional Feature:
Macro HCSR04_SCAN_FILT_EN.
- Defined: per-channel IIR smoothing.
  - First valid sample (rd_vld[i]==0) loads directly.
  - Later samples: len[i] <= (3*len[i] + rng_len) >> 2, computed in CAP_LEN+2 bits, truncated.
  - TOUT writes all-ones and clears rd_vld[i], so the next good sample reloads directly.
- Undefined: STORE writes rng_len raw. No extra logic.

Test Plan:
- Bench params GAP_CYC=20, TMO_CYC=100, engine model returns lengths after 30 cycles; all tests start with rst=0 for 3 cycles.
- Reset: hold rst=0 for 3 cycles → all outputs 0, state IDLE, no rng_en. Release with run=0 → stays idle.
- Scan: ch_mask=4'b1011, run=1, model lengths 100/200/–/400 → sel sequence 0,1,3,0; rd_len for ch0/1/3 = 100/200/400; rd_vld=4'b1011; sweep_done pulses after ch3.
- Timeout: model never raises rng_done on ch1 → after 100 cycles err[1]=1, len[1]=16'hFFFF, scan continues to ch3 after a 20-cycle gap.
- Stop/mask: drop run during ch0 MEAS → ch0 stored, 20-cycle gap, IDLE, busy=0. Set ch_mask=0 with run=1 → no rng_en.
- Filter (macro defined): ch0 samples 100 then 200 → stored 100 then 125. Timeout then sample 40 → stored 40.

Source files
------------

// File: rtl/hcsr04_scan.sv
// rtl/hcsr04_scan.sv - round-robin scheduler sharing one hcsr04 ranging engine across N_CH sensors
// Define HCSR04_SCAN_FILT_EN for per-channel IIR smoothing of stored lengths.
module hcsr04_scan #(
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int CAP_LEN = 16,
  parameter int GAP_CYC = 3000000,
  parameter int GAP_W   = 22,
  parameter int TMO_CYC = 2500000,
  parameter int TMO_W   = 22
) (
  input  logic               clk50M,
  input  logic               rst,
  input  logic               run,
  input  logic [N_CH-1:0]    ch_mask,
  output logic               rng_en,
  input  logic               rng_done,
  input  logic [CAP_LEN-1:0] rng_len,
  output logic [CH_W-1:0]    sel,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [CAP_LEN-1:0] rd_len,
  output logic [N_CH-1:0]    rd_vld,
  output logic [N_CH-1:0]    err,
  output logic               busy,
  output logic               sweep_done
);

  if (GAP_CYC < 1 || 64'(GAP_CYC) > (64'd1 << GAP_W)) begin : g_gap_chk
    $error("GAP_W too narrow for GAP_CYC");
  end
  if (TMO_CYC < 1 || 64'(TMO_CYC) > (64'd1 << TMO_W)) begin : g_tmo_chk
    $error("TMO_W too narrow for TMO_CYC");
  end
  if (N_CH < 2 || N_CH > (1 << CH_W)) begin : g_ch_chk
    $error("CH_W too narrow for N_CH");
  end

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEAS, S_STORE, S_TOUT, S_GAP} state_t;

  state_t             state, state_nxt;
  logic [TMO_W-1:0]   wd;
  logic [GAP_W-1:0]   gap_cnt;
  logic               fired;
  logic [CAP_LEN-1:0] len_q [N_CH];
  logic [CH_W-1:0]    sel_first, sel_after;
  logic               wd_exp, gap_end, go_on;

  // First enabled channel at or after start, wrapping past N_CH-1.
  function automatic logic [CH_W-1:0] pick(input logic [N_CH-1:0] mask, input int start);
    logic [CH_W-1:0] r;
    logic            found;
    int              idx;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx = start + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && mask[CH_W'(idx)]) begin
        r     = CH_W'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    int nxt;
    nxt = int'(sel) + 1;
    if (nxt >= N_CH) nxt = 0;
    sel_first = pick(ch_mask, int'(sel));
    sel_after = pick(ch_mask, nxt);
  end

  assign wd_exp  = (wd == TMO_W'(TMO_CYC - 1));
  assign gap_end = (gap_cnt == GAP_W'(GAP_CYC - 1));
  assign go_on   = run && (|ch_mask);

`ifdef HCSR04_SCAN_FILT_EN
  logic [CAP_LEN+1:0] acc;
  always_comb acc = ({2'b00, len_q[sel]} << 1) + {2'b00, len_q[sel]} + {2'b00, rng_len};
`endif

  always_ff @(posedge clk50M) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (go_on && rng_done) state_nxt = S_ARM;
      S_ARM: begin
        if (wd_exp)                 state_nxt = S_TOUT;
        else if (fired && !rng_done) state_nxt = S_MEAS;
      end
      S_MEAS: begin
        if (rng_done)    state_nxt = S_STORE;
        else if (wd_exp) state_nxt = S_TOUT;
      end
      S_STORE, S_TOUT: state_nxt = S_GAP;
      S_GAP:   if (gap_end) state_nxt = go_on ? S_ARM : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rng_en     = (state == S_ARM) && fired;
    busy       = (state != S_IDLE);
    sweep_done = (state == S_GAP) && gap_end && go_on && (sel_after <= sel);
  end

  // fired: engine has been seen idle in this ARM, so rng_en may be raised.
  always_ff @(posedge clk50M) begin
    if (!rst) begin
      sel     <= '0;
      fired   <= 1'b0;
      wd      <= '0;
      gap_cnt <= '0;
      rd_len  <= '0;
      rd_vld  <= '0;
      err     <= '0;
      for (int i = 0; i < N_CH; i++) len_q[i] <= '0;
    end else begin
      rd_len <= len_q[rd_ch];
      unique case (state)
        S_IDLE: begin
          if (state_nxt == S_ARM) begin
            sel   <= sel_first;
            fired <= 1'b1;
            wd    <= '0;
          end
        end
        S_ARM: begin
          if (rng_done) fired <= 1'b1;
          wd <= (state_nxt == S_MEAS) ? '0 : wd + TMO_W'(1);
        end
        S_MEAS: wd <= wd + TMO_W'(1);
        S_STORE: begin
`ifdef HCSR04_SCAN_FILT_EN
          if (rd_vld[sel]) len_q[sel] <= acc[CAP_LEN+1:2];
          else             len_q[sel] <= rng_len;
`else
          len_q[sel] <= rng_len;
`endif
          err[sel]    <= 1'b0;
          rd_vld[sel] <= 1'b1;
          gap_cnt     <= '0;
        end
        S_TOUT: begin
          len_q[sel] <= {CAP_LEN{1'b1}};
          err[sel]   <= 1'b1;
`ifdef HCSR04_SCAN_FILT_EN
          rd_vld[sel] <= 1'b0;
`else
          rd_vld[sel] <= 1'b1;
`endif
          gap_cnt <= '0;
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (state_nxt == S_ARM) begin
            sel   <= sel_after;
            fired <= 1'b0;
            wd    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hcsr04_scan.sv
// tb/tb_hcsr04_scan.sv - scoreboard bench for hcsr04_scan with a behavioural ranging engine
module tb_hcsr04_scan;
  localparam int N_CH = 4, CH_W = 2, CAP_LEN = 16;
  localparam int GAP_CYC = 20, GAP_W = 22, TMO_CYC = 100, TMO_W = 22;

  logic               clk50M = 1'b0;
  logic               rst, run, rng_done, rng_en, busy, sweep_done;
  logic [N_CH-1:0]    ch_mask, rd_vld, err;
  logic [CAP_LEN-1:0] rng_len, rd_len;
  logic [CH_W-1:0]    sel, rd_ch;

  int total = 0;
  int bad   = 0;

  logic [CAP_LEN-1:0] eng_len [N_CH];
  bit                 no_echo [N_CH];
  int                 sel_q[$];
  int                 sweep_q[$];
  int                 rd_exp_q[$];
  int                 rd_ch_q[$];
  bit                 rd_req  = 1'b0;
  bit                 en_prev = 1'b0;

  hcsr04_scan #(
    .N_CH(N_CH), .CH_W(CH_W), .CAP_LEN(CAP_LEN),
    .GAP_CYC(GAP_CYC), .GAP_W(GAP_W), .TMO_CYC(TMO_CYC), .TMO_W(TMO_W)
  ) dut (
    .clk50M(clk50M), .rst(rst), .run(run), .ch_mask(ch_mask),
    .rng_en(rng_en), .rng_done(rng_done), .rng_len(rng_len),
    .sel(sel), .rd_ch(rd_ch), .rd_len(rd_len), .rd_vld(rd_vld),
    .err(err), .busy(busy), .sweep_done(sweep_done)
  );

  always #10 clk50M = ~clk50M;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Engine: done drops when enabled, result after 30 cycles (150 for a silent channel).
  initial begin : engine
    int ch;
    rng_done = 1'b1;
    rng_len  = '0;
    forever begin
      @(negedge clk50M);
      if (rng_en && rng_done) begin
        ch       = int'(sel);
        rng_done = 1'b0;
        repeat (no_echo[ch] ? 150 : 30) @(negedge clk50M);
        rng_len  = eng_len[ch];
        rng_done = 1'b1;
      end
    end
  end

  always @(posedge clk50M) begin : monitor
    bit req_s;
    int e, c;
    req_s = rd_req;
    #1;
    if (rng_en && !en_prev) begin
      if (sel_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_start: sel=%0d with nothing expected", sel);
      end else begin
        e = sel_q.pop_front();
        check("start_sel", 32'(sel), 32'(e));
      end
    end
    en_prev = rng_en;
    if (sweep_done) begin
      if (sweep_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_sweep: sel=%0d with nothing expected", sel);
      end else begin
        e = sweep_q.pop_front();
        check("sweep_sel", 32'(sel), 32'(e));
      end
    end
    if (req_s) begin
      e = rd_exp_q.pop_front();
      c = rd_ch_q.pop_front();
      check($sformatf("rd_len_ch%0d", c), 32'(rd_len), 32'(e));
    end
  end

  task automatic rd_check(input int ch, input int exp);
    @(negedge clk50M);
    rd_ch = CH_W'(ch);
    rd_exp_q.push_back(exp);
    rd_ch_q.push_back(ch);
    rd_req = 1'b1;
    @(negedge clk50M);
    rd_req = 1'b0;
    @(negedge clk50M);
  endtask

  task automatic wait_starts(input string name, input int budget);
    int n;
    n = 0;
    while (sel_q.size() != 0 && n < budget) begin
      @(negedge clk50M);
      n++;
    end
    total++;
    if (sel_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d starts pending after %0d cycles", name, sel_q.size(), n);
      sel_q.delete();
    end
  endtask

  task automatic wait_idle(input string name, input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk50M);
      n++;
    end
    check(name, 32'(busy), 32'(0));
  endtask

  initial begin : stim
    int  n;
    bit  saw_en;
    rst     = 1'b0;
    run     = 1'b0;
    ch_mask = '0;
    rd_ch   = '0;
    eng_len = '{16'd100, 16'd200, 16'd300, 16'd400};
    no_echo = '{default: 1'b0};

    repeat (3) @(posedge clk50M);
    @(negedge clk50M);
    check("rst_rng_en", 32'(rng_en), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_sel", 32'(sel), 32'(0));
    check("rst_sweep", 32'(sweep_done), 32'(0));
    check("rst_rd_vld", 32'(rd_vld), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_rd_len", 32'(rd_len), 32'(0));
    rst = 1'b1;

    saw_en = 1'b0;
    repeat (10) begin
      @(negedge clk50M);
      saw_en |= rng_en;
    end
    check("idle_no_run_en", 32'(saw_en), 32'(0));
    check("idle_no_run_busy", 32'(busy), 32'(0));

    // Scan 0,1,3,0 then stop during the second ch0 measurement.
    sel_q   = '{0, 1, 3, 0};
    sweep_q = '{3};
    ch_mask = 4'b1011;
    run     = 1'b1;
    wait_starts("scan_starts", 400);
    eng_len[0] = 16'd200;
    run        = 1'b0;
    wait_idle("stop_idle", 200, n);
    total++;
    if (n < 50 || n > 54) begin
      bad++;
      $display("FAIL stop_gap_len: idle after %0d cycles, want 50..54", n);
    end
`ifdef HCSR04_SCAN_FILT_EN
    rd_check(0, 125);
`else
    rd_check(0, 200);
`endif
    rd_check(1, 200);
    rd_check(2, 0);
    rd_check(3, 400);
    check("scan_rd_vld", 32'(rd_vld), 32'(4'b1011));
    check("scan_err", 32'(err), 32'(0));

    // Empty mask with run high must never start a measurement.
    ch_mask = '0;
    run     = 1'b1;
    saw_en  = 1'b0;
    repeat (50) begin
      @(negedge clk50M);
      saw_en |= rng_en;
    end
    check("mask0_no_en", 32'(saw_en), 32'(0));
    check("mask0_busy", 32'(busy), 32'(0));
    run = 1'b0;

    // Channel 1 never answers: watchdog fires, scan moves on to ch3.
    eng_len[0] = 16'd111;
    eng_len[3] = 16'd333;
    no_echo[1] = 1'b1;
    sel_q      = '{0, 1, 3};
    ch_mask    = 4'b1011;
    run        = 1'b1;
    wait_starts("tmo_starts", 600);
    run = 1'b0;
    wait_idle("tmo_idle", 300, n);
    check("tmo_err", 32'(err), 32'(4'b0010));
    rd_check(1, 16'hFFFF);
`ifdef HCSR04_SCAN_FILT_EN
    rd_check(0, 121);
    rd_check(3, 383);
    check("tmo_rd_vld", 32'(rd_vld), 32'(4'b1001));
`else
    rd_check(0, 111);
    rd_check(3, 333);
    check("tmo_rd_vld", 32'(rd_vld), 32'(4'b1011));
`endif

    // Single enabled channel: sweep pulses on every wrap; good sample after timeout.
    no_echo[1] = 1'b0;
    eng_len[1] = 16'd40;
    sel_q      = '{1, 1};
    sweep_q    = '{1};
    ch_mask    = 4'b0010;
    run        = 1'b1;
    wait_starts("single_starts", 400);
    run = 1'b0;
    wait_idle("single_idle", 200, n);
    rd_check(1, 40);
    check("single_err", 32'(err), 32'(0));
    check("single_rd_vld", 32'(rd_vld), 32'(4'b1011));

    repeat (5) @(negedge clk50M);
    check("sweep_pending", 32'(sweep_q.size()), 32'(0));
    check("start_pending", 32'(sel_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #(20 * 20000);
    $display("FAIL global_timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
